// File: rtl/switch_bank_ctrl.sv
// Switch bank: sync + debounce (SWITCH_BANK_DEBOUNCE_EN) of board switches, halfword deb/flag/mask banks, level irq.
// Latency: read data one falling edge after strobe; deb 2 edges (no debounce) or 2 + DB_SAMPLES*DB_TICK worst case.
// Backpressure: none, every strobe is accepted on the falling edge it is sampled.
module switch_bank_ctrl #(
    parameter int SW_WIDTH   = 24,
    parameter int ADDR_W     = 4,
    parameter int DB_TICK    = 20000,
    parameter int DB_SAMPLES = 3
) (
    input  logic                switclk,
    input  logic                switrst,
    input  logic                switchcs,
    input  logic                switchread,
    input  logic                switchwrite,
    input  logic [ADDR_W-1:0]   switchaddr,
    input  logic [15:0]         switchwdata,
    output logic [15:0]         switchrdata,
    input  logic [SW_WIDTH-1:0] switch_i,
    output logic                switchirq
);
    localparam int NB = (SW_WIDTH + 15) / 16;
    localparam int PW = NB * 16;
    localparam int IW = ADDR_W - 1;

    logic [SW_WIDTH-1:0] sync1_q, sync2_q;
    logic [SW_WIDTH-1:0] deb_q, deb_d;
    logic [SW_WIDTH-1:0] flag_q, flag_d;
    logic [SW_WIDTH-1:0] mask_q, mask_d;
    logic [SW_WIDTH-1:0] w1c;
    logic [15:0]         rdata_q, rdata_d;
    logic [PW-1:0]       deb_pad, flag_pad, mask_pad;
    logic [IW-1:0]       idx;
    logic                rd_en, wr_en;
    logic                addr_lsb_unused;

    assign idx             = switchaddr[ADDR_W-1:1];
    assign addr_lsb_unused = switchaddr[0];
    assign rd_en           = switchcs && switchread;
    assign wr_en           = switchcs && switchwrite;

`ifdef SWITCH_BANK_DEBOUNCE_EN
    localparam int CW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;

    logic [CW-1:0]                       cnt_q, cnt_d;
    logic                                tick;
    logic [SW_WIDTH-1:0][DB_SAMPLES-1:0] hist_q, hist_d;

    assign tick = (cnt_q == CW'(DB_TICK - 1));

    // A level is accepted only once the whole history agrees on it.
    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        hist_d = hist_q;
        deb_d  = deb_q;
        if (tick) begin
            for (int i = 0; i < SW_WIDTH; i++) begin
                hist_d[i] = {hist_q[i][DB_SAMPLES-2:0], sync2_q[i]};
                if (&hist_d[i])
                    deb_d[i] = 1'b1;
                else if (~|hist_d[i])
                    deb_d[i] = 1'b0;
            end
        end
    end

    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            cnt_q  <= '0;
            hist_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hist_q <= hist_d;
        end
    end
`else
    localparam int db_params_unused = DB_TICK + DB_SAMPLES;

    // deb_q tracks sync2_q exactly, so its next value is the next sync2 value.
    assign deb_d = sync1_q;
`endif

    always_comb begin
        w1c    = '0;
        mask_d = mask_q;
        for (int i = 0; i < SW_WIDTH; i++) begin
            if (wr_en && idx == IW'(NB + i / 16))
                w1c[i] = switchwdata[i % 16];
            if (wr_en && idx == IW'(2 * NB + i / 16))
                mask_d[i] = switchwdata[i % 16];
        end
        // A new change event beats a clear landing on the same edge.
        flag_d = (flag_q & ~w1c) | (deb_d ^ deb_q);
    end

    assign deb_pad  = PW'(deb_q);
    assign flag_pad = PW'(flag_q);
    assign mask_pad = PW'(mask_q);

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = 16'h0000;
            for (int b = 0; b < NB; b++) begin
                if (idx == IW'(b))
                    rdata_d = deb_pad[16*b +: 16];
                if (idx == IW'(NB + b))
                    rdata_d = flag_pad[16*b +: 16];
                if (idx == IW'(2 * NB + b))
                    rdata_d = mask_pad[16*b +: 16];
            end
        end
    end

    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            flag_q  <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            sync1_q <= switch_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            flag_q  <= flag_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    assign switchrdata = rdata_q;
    assign switchirq   = |(flag_q & mask_q);

endmodule
